vga_image_scaler: RTL and testbench
===================================

Name: vga_image_scaler

Overview:
- Parametrised image-fetch stage between the VGA timing driver and the synchronous image ROM.
- Replaces the fixed "y*640+x" address computation with incremental, multiplier-free address generation.
- Supports an IMG_W x IMG_H image placed at offset (X0,Y0) and a runtime integer zoom of 1x/2x/4x using nearest-neighbour replication.
- Compensates the ROM read latency and outputs BG_COLOR for pixels outside the image window.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- X0, 0, left edge of the window on screen
- Y0, 0, top edge of the window on screen
- COORD_W, 10, width of the screen coordinate inputs
- COLOR_W, 8, pixel colour width
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- BG_COLOR, 8'h00, colour for out-of-window or unsynchronised pixels

Ports:
- clock  in  1  pixel clock (same clock as the VGA driver and ROM)
- reset  in  1  asynchronous, active-high reset
- zoom  in  2  zoom select: 0=1x, 1=2x, 2=4x, 3=treated as 1x
- x_in  in  COORD_W  next pixel x from the driver
- y_in  in  COORD_W  next pixel y from the driver
- valid_in  in  1  x_in/y_in lie inside the active area
- mem_addr  out  ADDR_W  ROM read address (registered)
- mem_q  in  COLOR_W  ROM data, valid one cycle after mem_addr
- color_out  out  COLOR_W  pixel colour to the driver
- valid_out  out  1  color_out corresponds to an active pixel

Behaviour:
- Reset values:
  - mem_addr=0, color_out=0, valid_out=0.
  - All counters 0; zoom_q=0; frame_ok=0.
- Frame start: the cycle with valid_in=1, x_in=0, y_in=0.
  - Latch zoom into zoom_q, giving shift s = 0/1/2 (code 3 -> s=0).
  - Clear row_base, row_rep, col_addr and col_rep.
  - Set frame_ok=1.
- zoom changes at any other time are ignored until the next frame start.
- Window (evaluated with zoom_q):
  - in_win = valid_in && frame_ok && X0 <= x_in < X0+(IMG_W<<s) && Y0 <= y_in < Y0+(IMG_H<<s).
  - Parts of the window beyond the screen are clipped. Those pixels never occur, so counters do not advance for them.
- Column stepping, only on in_win cycles:
  - At x_in==X0, the address is row_base; set col_addr=0 and col_rep=0.
  - Otherwise col_rep increments. When col_rep reaches (1<<s)-1 it wraps to 0 and col_addr increments.
  - Address issued = row_base + col_addr.
- Row stepping: on the in_win cycle with x_in==X0+(IMG_W<<s)-1:
  - row_rep increments.
  - When row_rep reaches (1<<s)-1 it wraps to 0 and row_base += IMG_W.
  - At the last image row, row_base is not incremented further; it is cleared at the next frame start.
- Pipeline:
  - Stage 1 (cycle N+1): mem_addr is registered. When in_win=0, mem_addr holds its previous value. in_win and valid_in are delayed along with it.
  - Stage 2 (cycle N+2): color_out = in_win_d2 ? mem_q : BG_COLOR; valid_out = valid_in_d2.
  - Total latency from x_in/y_in to color_out is 2 cycles. The pipeline has no stall or backpressure.
- Gaps in valid_in mid-row: counters hold, and stepping resumes on the next in_win cycle.
- Reset mid-frame:
  - All state clears asynchronously.
  - Until the next frame start, frame_ok=0, so every valid pixel outputs BG_COLOR with valid_out tracking valid_in.
- Arithmetic:
  - row_base and col_addr are ADDR_W wide.
  - Window limits are computed at COORD_W+3 bits, so the shifted widths do not overflow.

Decomposition:
- Shared package vga_pkg holds:
  - constants H_ACTIVE=640 and V_ACTIVE=480;
  - the zoom encoding constants ZOOM_1X/ZOOM_2X/ZOOM_4X;
  - a clog2 helper for ADDR_W.
- One natural sub-module, scale_counter: the replicate-then-advance counter (rep counter plus index counter, with load/step/shift inputs).
  - Instantiated twice: once for columns (step by 1) and once for rows (step by IMG_W).

Test Plan:
1. Default params, zoom=1 (2x), full 640x480 frame after frame start:
   - mem_addr sequence on row y=0 is 0,0,1,1,...,319,319.
   - Row y=1 repeats 0..319; row y=2 starts at 320.
   - Last pixel (639,479) gives mem_addr 76799.
   - color_out equals mem_q of that address, 2 cycles later.
2. zoom=0 (1x), X0=100, Y0=50:
   - (99,50) gives BG_COLOR.
   - (100,50) gives address 0; (419,50) gives address 319; (420,50) gives BG_COLOR.
   - (100,289) gives address 76480; (100,290) gives BG_COLOR.
3. zoom=2 (4x), window clipped at 640x480:
   - Row y=0 addresses are 0 x4, 1 x4, ..., 159 x4.
   - Row y=4 starts at 320.
   - No address exceeds 119*320+159.
4. zoom switched from 0 to 1 at y=200:
   - The current frame continues at 1x.
   - The next frame start applies 2x (row 0 shows the 0,0,1,1 pattern).
5. reset pulsed at (300,200):
   - All outputs are 0 immediately.
   - Remaining valid pixels give BG_COLOR with valid_out=1 two cycles after valid_in.
   - The following frame displays correctly from address 0.
6. valid_in deasserted for 10 cycles mid-row at x=50, zoom=0:
   - mem_addr holds.
   - The next valid pixel gets the next address with no skip.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA image-fetch path.
//   H_ACTIVE / V_ACTIVE : visible screen size in pixels
//   ZOOM_*              : encoding of the zoom select input
//   clog2               : address-width helper for image sizes
//   zoom_shift          : zoom code -> replication shift (unknown codes act as 1x)
//   rep_last            : last replica index for a given shift, (1<<s)-1
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [1:0] ZOOM_1X = 2'd0;
    localparam logic [1:0] ZOOM_2X = 2'd1;
    localparam logic [1:0] ZOOM_4X = 2'd2;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic logic [1:0] zoom_shift(input logic [1:0] zoom);
        case (zoom)
            ZOOM_2X: return 2'd1;
            ZOOM_4X: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] rep_last(input logic [1:0] shift);
        case (shift)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/scale_counter.sv
// scale_counter: replicate-then-advance counter used for nearest-neighbour zoom.
// Each index value is held for (1<<shift) steps, then advances by STEP.
//   clock, reset : pixel clock, asynchronous active-high reset
//   load         : clear replica and index (start of a row / frame)
//   step         : advance one replica position
//   hold         : suppress the index advance when the replica count wraps
//   shift        : replication shift (0 = 1x, 1 = 2x, 2 = 4x)
//   idx          : USE_NEXT=1 -> index after this cycle's update (column use)
//                  USE_NEXT=0 -> index in effect before the update (row use)
module scale_counter
    import vga_pkg::*;
#(
    parameter int IDX_W    = 17,
    parameter int STEP     = 1,
    parameter bit USE_NEXT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             hold,
    input  logic [1:0]       shift,
    output logic [IDX_W-1:0] idx
);

    logic [1:0]       rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        rep_d = rep_q;
        idx_d = idx_q;
        if (load) begin
            rep_d = '0;
            idx_d = '0;
        end else if (step) begin
            if (rep_q >= rep_last(shift)) begin
                rep_d = '0;
                if (!hold) idx_d = idx_q + IDX_W'(STEP);
            end else begin
                rep_d = rep_q + 2'd1;
            end
        end
        if (USE_NEXT) idx = idx_d;
        else          idx = load ? '0 : idx_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
            idx_q <= '0;
        end else begin
            rep_q <= rep_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/vga_image_scaler.sv
// vga_image_scaler: image-fetch stage between the VGA timing driver and a
// synchronous image ROM. Generates ROM addresses incrementally (no multiplier)
// for an IMG_W x IMG_H image at (X0,Y0) with 1x/2x/4x replication, and
// outputs BG_COLOR outside the window. Latency from x_in/y_in to color_out is 2.
//   clock, reset   : pixel clock, asynchronous active-high reset
//   zoom           : 0=1x, 1=2x, 2=4x, 3=1x; sampled only at frame start
//   x_in, y_in     : next pixel coordinate from the driver
//   valid_in       : coordinate lies in the active area
//   mem_addr       : registered ROM address
//   mem_q          : ROM data, one cycle after mem_addr
//   color_out      : pixel colour to the driver
//   valid_out      : color_out belongs to an active pixel
module vga_image_scaler
    import vga_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int X0      = 0,
    parameter int Y0      = 0,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = clog2(IMG_W * IMG_H),
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         zoom,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic               valid_in,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [COLOR_W-1:0] mem_q,
    output logic [COLOR_W-1:0] color_out,
    output logic               valid_out
);

    localparam int LIM_W = COORD_W + 3;
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((IMG_H - 1) * IMG_W);

    logic              frame_start, ok_eff, in_win, at_x0;
    logic [1:0]        zoom_eff, shift;
    logic [LIM_W-1:0]  x_ext, y_ext, x_lim, y_lim, x_end;
    logic              col_load, col_step, row_step, row_hold;
    logic [ADDR_W-1:0] col_addr, row_base;

    logic [1:0]        zoom_q, zoom_d;
    logic              frame_ok_q, frame_ok_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              in_win_p1_q, in_win_p1_d, vld_p1_q, vld_p1_d;
    logic              in_win_p2_q, in_win_p2_d, vld_p2_q, vld_p2_d;

    always_comb begin
        frame_start = valid_in && (x_in == '0) && (y_in == '0);
        // The frame-start pixel itself already uses the newly latched zoom.
        zoom_eff    = frame_start ? zoom : zoom_q;
        ok_eff      = frame_start || frame_ok_q;
        shift       = zoom_shift(zoom_eff);

        x_ext = LIM_W'(x_in);
        y_ext = LIM_W'(y_in);
        x_lim = LIM_W'(X0) + (LIM_W'(IMG_W) << shift);
        y_lim = LIM_W'(Y0) + (LIM_W'(IMG_H) << shift);
        // A window running off the right of the screen ends its rows at the
        // last visible column, otherwise the row counter would never step.
        x_end = (x_lim > LIM_W'(H_ACTIVE)) ? LIM_W'(H_ACTIVE - 1) : x_lim - LIM_W'(1);

        in_win = valid_in && ok_eff
              && (x_ext >= LIM_W'(X0)) && (x_ext < x_lim)
              && (y_ext >= LIM_W'(Y0)) && (y_ext < y_lim)
              && (y_ext < LIM_W'(V_ACTIVE));
        at_x0  = (x_ext == LIM_W'(X0));

        col_load = frame_start || (in_win && at_x0);
        col_step = in_win && !at_x0;
        row_step = in_win && (x_ext == x_end);
        row_hold = (row_base == LAST_BASE);

        zoom_d     = zoom_eff;
        frame_ok_d = ok_eff;
        mem_addr_d = in_win ? row_base + col_addr : mem_addr_q;

        in_win_p1_d = in_win;
        vld_p1_d    = valid_in;
        in_win_p2_d = in_win_p1_q;
        vld_p2_d    = vld_p1_q;
    end

    scale_counter #(.IDX_W(ADDR_W), .STEP(1), .USE_NEXT(1'b1)) u_col (
        .clock (clock),
        .reset (reset),
        .load  (col_load),
        .step  (col_step),
        .hold  (1'b0),
        .shift (shift),
        .idx   (col_addr)
    );

    scale_counter #(.IDX_W(ADDR_W), .STEP(IMG_W), .USE_NEXT(1'b0)) u_row (
        .clock (clock),
        .reset (reset),
        .load  (frame_start),
        .step  (row_step),
        .hold  (row_hold),
        .shift (shift),
        .idx   (row_base)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zoom_q      <= '0;
            frame_ok_q  <= 1'b0;
            mem_addr_q  <= '0;
            in_win_p1_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            in_win_p2_q <= 1'b0;
            vld_p2_q    <= 1'b0;
        end else begin
            zoom_q      <= zoom_d;
            frame_ok_q  <= frame_ok_d;
            // stage 1: address to ROM
            mem_addr_q  <= mem_addr_d;
            in_win_p1_q <= in_win_p1_d;
            vld_p1_q    <= vld_p1_d;
            // stage 2: ROM data arrives, select pixel or background
            in_win_p2_q <= in_win_p2_d;
            vld_p2_q    <= vld_p2_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign color_out = in_win_p2_q ? mem_q : BG_COLOR;
    assign valid_out = vld_p2_q;

endmodule

// File: tb/tb_vga_image_scaler.sv
module tb_vga_image_scaler;

    localparam int W = 320;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  zoom;
    logic [9:0]  x_in, y_in;
    logic        valid_in;
    logic [16:0] mem_addr_a, mem_addr_b;
    logic [7:0]  mem_q_a, mem_q_b, color_a, color_b;
    logic        vout_a, vout_b;
    logic        chk_en;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_image_scaler #(.X0(0), .Y0(0)) u_a (
        .clock(clk), .reset(rst), .zoom(zoom), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .mem_addr(mem_addr_a), .mem_q(mem_q_a),
        .color_out(color_a), .valid_out(vout_a)
    );

    vga_image_scaler #(.X0(100), .Y0(50)) u_b (
        .clock(clk), .reset(rst), .zoom(zoom), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .mem_addr(mem_addr_b), .mem_q(mem_q_b),
        .color_out(color_b), .valid_out(vout_b)
    );

    // Synchronous ROM models with address-dependent content.
    function automatic logic [7:0] rom_val(input logic [16:0] a);
        return 8'(a * 17'd7 + 17'h5A) ^ 8'(a >> 8);
    endfunction

    always @(posedge clk) begin
        mem_q_a <= rom_val(mem_addr_a);
        mem_q_b <= rom_val(mem_addr_b);
    end

    task automatic check(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected address of an in-window pixel is simply
    //   ((y-Y0)>>s)*IMG_W + ((x-X0)>>s); outside the window the address holds.
    typedef struct packed {
        logic        vld;
        logic        win;
        logic [16:0] addr;
        logic        achk;
        logic        cchk;
        logic        lv;
    } ent_t;

    localparam ent_t RST_E = '{vld: 1'b0, win: 1'b0, addr: 17'd0,
                               achk: 1'b1, cchk: 1'b1, lv: 1'b1};

    int   X0S [2] = '{0, 100};
    int   Y0S [2] = '{0, 50};
    ent_t s1 [2];
    ent_t s2 [2];
    logic [1:0] zm [2];
    logic       ok [2];

    function automatic logic fs();
        return valid_in && (x_in == 10'd0) && (y_in == 10'd0);
    endfunction

    function automatic ent_t predict(input int i, input logic [1:0] z, input logic o,
                                     input ent_t prev, input logic ce);
        ent_t e;
        int sh, xi, yi;
        sh = (z == 2'd1) ? 1 : (z == 2'd2) ? 2 : 0;
        xi = int'(x_in);
        yi = int'(y_in);
        e.vld  = valid_in;
        e.win  = valid_in && o && xi >= X0S[i] && xi < X0S[i] + (W << sh)
                 && yi >= Y0S[i] && yi < Y0S[i] + (H << sh);
        e.addr = e.win ? 17'(((yi - Y0S[i]) >> sh) * W + ((xi - X0S[i]) >> sh)) : prev.addr;
        e.lv   = e.win ? ce : prev.lv;
        e.achk = ce && (e.win || prev.lv);
        e.cchk = ce;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                s1[i] <= RST_E;
                s2[i] <= RST_E;
                zm[i] <= 2'd0;
                ok[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                s1[i] <= predict(i, fs() ? zoom : zm[i], fs() || ok[i], s1[i], chk_en);
                s2[i] <= s1[i];
                if (fs()) begin
                    zm[i] <= zoom;
                    ok[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s1[0].achk) check("model_addr_a", int'(mem_addr_a), int'(s1[0].addr));
            if (s1[1].achk) check("model_addr_b", int'(mem_addr_b), int'(s1[1].addr));
            if (s2[0].cchk) begin
                check("model_valid_a", int'(vout_a), int'(s2[0].vld));
                check("model_color_a", int'(color_a),
                      s2[0].win ? int'(rom_val(s2[0].addr)) : 0);
            end
            if (s2[1].cchk) begin
                check("model_valid_b", int'(vout_b), int'(s2[1].vld));
                check("model_color_b", int'(color_b),
                      s2[1].win ? int'(rom_val(s2[1].addr)) : 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pix(input int x, input int y, input logic v = 1'b1);
        x_in     = 10'(x);
        y_in     = 10'(y);
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic row_part(input int y, input int xa, input int xb);
        for (int x = xa; x <= xb; x++) pix(x, y);
    endtask

    // Rows that only present their row-end columns; addresses there are not
    // scan-order addresses, so model comparisons are suspended.
    task automatic sparse(input int ya, input int yb);
        chk_en = 1'b0;
        for (int y = ya; y <= yb; y++) begin
            pix(319, y);
            pix(419, y);
            pix(639, y);
        end
        chk_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; zoom = 2'd0; x_in = '0; y_in = '0; valid_in = 1'b0; chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_a", int'(mem_addr_a), 0);
        check("rst_color_a", int'(color_a), 0);
        check("rst_valid_a", int'(vout_a), 0);
        rst = 1'b0;

        // 2x full-width scan
        zoom = 2'd1;
        pix(0, 0); check("t1_x0", int'(mem_addr_a), 0);
        pix(1, 0); check("t1_x1", int'(mem_addr_a), 0);
        pix(2, 0); check("t1_x2", int'(mem_addr_a), 1);
        pix(3, 0); check("t1_x3", int'(mem_addr_a), 1);
        row_part(0, 4, 639); check("t1_row0_end", int'(mem_addr_a), 319);
        pix(0, 1); check("t1_row1_start", int'(mem_addr_a), 0);
        row_part(1, 1, 639);
        pix(0, 2); check("t1_row2_start", int'(mem_addr_a), 320);
        row_part(2, 1, 639);
        sparse(3, 478);
        row_part(479, 0, 639); check("t1_last_addr", int'(mem_addr_a), 76799);
        pix(0, 0, 1'b0);
        check("t1_last_color", int'(color_a), int'(rom_val(17'd76799)));
        check("t1_last_valid", int'(vout_a), 1);
        pix(0, 0, 1'b0);

        // 1x, offset window on instance b
        zoom = 2'd0;
        pix(0, 0);
        sparse(0, 49);
        row_part(50, 0, 99);
        pix(100, 50);
        check("t2_addr_100_50", int'(mem_addr_b), 0);
        check("t2_bg_99_50", int'(color_b), 0);
        check("t2_valid_99_50", int'(vout_b), 1);
        pix(101, 50); check("t2_color_100_50", int'(color_b), 8'h5A);
        row_part(50, 102, 419); check("t2_addr_419_50", int'(mem_addr_b), 319);
        pix(420, 50);
        pix(421, 50); check("t2_bg_420_50", int'(color_b), 0);
        row_part(50, 422, 639);
        sparse(51, 288);
        row_part(289, 0, 100); check("t2_addr_100_289", int'(mem_addr_b), 76480);
        row_part(289, 101, 639);
        row_part(290, 0, 100);
        pix(101, 290);
        check("t2_bg_100_290", int'(color_b), 0);
        check("t2_valid_100_290", int'(vout_b), 1);
        pix(0, 0, 1'b0);

        // 4x, window clipped by the screen
        zoom = 2'd2;
        pix(0, 0); check("t3_x0", int'(mem_addr_a), 0);
        row_part(0, 1, 3); check("t3_x3", int'(mem_addr_a), 0);
        pix(4, 0); check("t3_x4", int'(mem_addr_a), 1);
        row_part(0, 5, 639); check("t3_row0_end", int'(mem_addr_a), 159);
        row_part(1, 0, 639);
        row_part(2, 0, 639);
        row_part(3, 0, 639);
        pix(0, 4); check("t3_row4_start", int'(mem_addr_a), 320);
        row_part(4, 1, 639);
        sparse(5, 478);
        row_part(479, 0, 639); check("t3_max_addr", int'(mem_addr_a), 38239);
        pix(0, 0, 1'b0);

        // zoom change mid-frame is deferred to the next frame
        zoom = 2'd0;
        pix(0, 0);
        row_part(0, 1, 639);
        sparse(1, 198);
        row_part(199, 0, 639);
        zoom = 2'd1;
        pix(0, 200); check("t4_still_1x", int'(mem_addr_a), 64000);
        row_part(200, 1, 639); check("t4_row200_hold", int'(mem_addr_a), 64319);
        pix(0, 0); check("t4_2x_x0", int'(mem_addr_a), 0);
        pix(1, 0); check("t4_2x_x1", int'(mem_addr_a), 0);
        pix(2, 0); check("t4_2x_x2", int'(mem_addr_a), 1);
        row_part(0, 3, 639);
        sparse(1, 198);
        row_part(199, 0, 639);
        row_part(200, 0, 300); check("t4_addr_300_200", int'(mem_addr_a), 32150);

        // reset mid-frame
        #1 rst = 1'b1;
        #1;
        check("t5_rst_addr_a", int'(mem_addr_a), 0);
        check("t5_rst_addr_b", int'(mem_addr_b), 0);
        check("t5_rst_color_a", int'(color_a), 0);
        check("t5_rst_valid_a", int'(vout_a), 0);
        #1 rst = 1'b0;
        pix(301, 200); check("t5_addr_after", int'(mem_addr_a), 0);
        pix(302, 200);
        check("t5_bg_color", int'(color_a), 0);
        check("t5_bg_valid", int'(vout_a), 1);
        row_part(200, 303, 639);
        row_part(201, 0, 639);
        pix(0, 0); check("t5_new_x0", int'(mem_addr_a), 0);
        pix(1, 0);
        pix(2, 0);
        check("t5_new_x2", int'(mem_addr_a), 1);
        check("t5_new_color", int'(color_a), 8'h5A);
        row_part(0, 3, 639);

        // valid gap mid-row
        zoom = 2'd0;
        pix(0, 0);
        row_part(0, 1, 49); check("t6_before_gap", int'(mem_addr_a), 49);
        for (int k = 0; k < 10; k++) pix(50, 0, 1'b0);
        check("t6_gap_hold", int'(mem_addr_a), 49);
        pix(50, 0); check("t6_resume", int'(mem_addr_a), 50);
        pix(51, 0);
        check("t6_resume_color", int'(color_a), int'(rom_val(17'd50)));
        check("t6_resume_valid", int'(vout_a), 1);
        row_part(0, 52, 639);
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
